// File: rtl/txbl_sequencer.sv
// Fill/scroll engine for the text-layer tile table; shares the single TXBL port
// with the CPU and stalls whenever the CPU claims it.
module txbl_sequencer #(
  parameter int ROWS   = 30,
  parameter int COLS   = 32,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              cpu_clk,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  input  logic              cmd_op_i,
  input  logic [DATA_W-1:0] cmd_fill_i,
  output logic              cmd_ready_o,
  input  logic              cpu_req_i,
  output logic              eng_active_o,
  output logic [ADDR_W-1:0] txbl_addr_o,
  output logic [DATA_W-1:0] txbl_wdata_o,
  output logic              txbl_wen_o,
  input  logic [DATA_W-1:0] txbl_rdata_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam int CW = $clog2(COLS);
  localparam logic [4:0]    LAST_ROW = 5'(ROWS - 1);
  localparam logic [4:0]    PEN_ROW  = 5'(ROWS - 2);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  typedef enum logic [2:0] {IDLE, FILL, SCR_RD, SCR_WR, SCR_FILL, DONE} state_t;

  state_t            state, state_nx;
  logic [4:0]        row, row_nx;
  logic [CW-1:0]     col, col_nx;
  logic [DATA_W-1:0] fill, fill_nx;
  logic [DATA_W-1:0] data, data_nx;
  logic              last_col;

  assign last_col = (col == LAST_COL);

  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
      fill  <= '0;
      data  <= '0;
    end else begin
      state <= state_nx;
      row   <= row_nx;
      col   <= col_nx;
      fill  <= fill_nx;
      data  <= data_nx;
    end
  end

  // Every state holds its counters while cpu_req_i is high, so a stalled
  // access is simply re-presented on the first free cycle.
  always_comb begin
    state_nx     = state;
    row_nx       = row;
    col_nx       = col;
    fill_nx      = fill;
    data_nx      = data;
    cmd_ready_o  = 1'b0;
    eng_active_o = 1'b0;
    txbl_addr_o  = '0;
    txbl_wdata_o = '0;
    txbl_wen_o   = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          fill_nx  = cmd_fill_i;
          row_nx   = '0;
          col_nx   = '0;
          state_nx = cmd_op_i ? SCR_RD : FILL;
        end
      end
      FILL: begin
        busy_o       = 1'b1;
        txbl_addr_o  = ADDR_W'({row, col});
        txbl_wdata_o = fill;
        if (!cpu_req_i) begin
          eng_active_o = 1'b1;
          txbl_wen_o   = 1'b1;
          col_nx       = col + 1'b1;
          if (last_col) begin
            if (row == LAST_ROW) begin
              row_nx   = '0;
              state_nx = DONE;
            end else begin
              row_nx = row + 5'd1;
            end
          end
        end
      end
      SCR_RD: begin
        busy_o      = 1'b1;
        txbl_addr_o = ADDR_W'({row + 5'd1, col});
        if (!cpu_req_i) begin
          eng_active_o = 1'b1;
          data_nx      = txbl_rdata_i;
          state_nx     = SCR_WR;
        end
      end
      SCR_WR: begin
        busy_o       = 1'b1;
        txbl_addr_o  = ADDR_W'({row, col});
        txbl_wdata_o = data;
        if (!cpu_req_i) begin
          eng_active_o = 1'b1;
          txbl_wen_o   = 1'b1;
          col_nx       = col + 1'b1;
          if (last_col && row == PEN_ROW) begin
            row_nx   = LAST_ROW;
            state_nx = SCR_FILL;
          end else begin
            if (last_col) row_nx = row + 5'd1;
            state_nx = SCR_RD;
          end
        end
      end
      SCR_FILL: begin
        busy_o       = 1'b1;
        txbl_addr_o  = ADDR_W'({LAST_ROW, col});
        txbl_wdata_o = fill;
        if (!cpu_req_i) begin
          eng_active_o = 1'b1;
          txbl_wen_o   = 1'b1;
          col_nx       = col + 1'b1;
          if (last_col) begin
            row_nx   = '0;
            state_nx = DONE;
          end
        end
      end
      DONE: begin
        done_o   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_txbl_sequencer.sv
// Directed bench for txbl_sequencer: behavioural TXBL array plus per-scenario tasks.
module tb_txbl_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_op, cmd_ready;
  logic [7:0] cmd_fill;
  logic       cpu_req, eng_active, txbl_wen, busy, done;
  logic [9:0] txbl_addr;
  logic [7:0] txbl_wdata, txbl_rdata;

  logic [7:0] mem [0:1023];
  logic       cpu_we;
  logic [9:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       init_go;
  int         init_mode;
  logic [7:0] init_val;

  int checks = 0, errors = 0;
  int wr_count = 0, bad_overlap = 0, bad_range = 0, bad_active = 0, done_count = 0;

  always #5 clk = ~clk;

  txbl_sequencer #(.ROWS(30), .COLS(32), .ADDR_W(10), .DATA_W(8)) dut (
    .cpu_clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_op_i(cmd_op), .cmd_fill_i(cmd_fill), .cmd_ready_o(cmd_ready),
    .cpu_req_i(cpu_req), .eng_active_o(eng_active),
    .txbl_addr_o(txbl_addr), .txbl_wdata_o(txbl_wdata), .txbl_wen_o(txbl_wen),
    .txbl_rdata_i(txbl_rdata), .busy_o(busy), .done_o(done)
  );

  assign txbl_rdata = mem[txbl_addr];

  always @(posedge clk) begin
    if (init_go) begin
      for (int i = 0; i < 1024; i++)
        mem[i] <= (init_mode == 1) ? (((i / 32) < 30) ? 8'((i / 32) + (i % 32)) : 8'hEE) : init_val;
    end else begin
      if (txbl_wen) mem[txbl_addr] <= txbl_wdata;
      if (cpu_we) mem[cpu_addr] <= cpu_wdata;
    end
  end

  always @(posedge clk) begin
    if (txbl_wen) begin
      wr_count++;
      if (cpu_req) bad_overlap++;
      if (txbl_addr >= 10'd960) bad_range++;
      if (!eng_active) bad_active++;
    end
    if (done) done_count++;
  end

  function automatic int count_bad_const(input logic [7:0] v, input int lo, input int hi);
    int bad = 0;
    for (int i = lo; i < hi; i++) if (mem[i] !== v) bad++;
    return bad;
  endfunction

  function automatic int count_bad_scroll(input logic [7:0] f, input int skip);
    int bad = 0;
    logic [7:0] e;
    for (int i = 0; i < 1024; i++) begin
      if (i / 32 < 29) e = 8'((i / 32) + 1 + (i % 32));
      else if (i / 32 == 29) e = f;
      else e = 8'hEE;
      if (i != skip && mem[i] !== e) bad++;
    end
    return bad;
  endfunction

  task automatic init_table(input int mode, input logic [7:0] v);
    @(negedge clk);
    init_mode = mode;
    init_val  = v;
    init_go   = 1'b1;
    @(negedge clk);
    init_go = 1'b0;
  endtask

  task automatic start_cmd(input logic op, input logic [7:0] f);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_fill  = f;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int every, output int n_done, output int stalls);
    int n = 0;
    n_done = 0;
    stalls = 0;
    while (n < budget && n_done == 0) begin
      @(negedge clk);
      n++;
      cpu_req = (every != 0 && n % every == 0);
      #1;
      if (done) n_done = n;
      else if (busy && cpu_req) stalls++;
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (txbl_wen !== 1'b0 || eng_active !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_strobes got wen=%b act=%b done=%b exp 0", txbl_wen, eng_active, done); end
    checks++; if (txbl_addr !== 10'd0 || txbl_wdata !== 8'd0) begin
      errors++; $display("FAIL reset_addr got %0h/%0h exp 0/0", txbl_addr, txbl_wdata); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill;
    int n = 0, nd = 0, w0;
    init_table(0, 8'hAA);
    w0 = wr_count;
    start_cmd(1'b0, 8'h20);
    while (n < 2000 && nd == 0) begin
      @(negedge clk);
      n++;
      if (n == 100) begin cmd_valid = 1'b1; cmd_op = 1'b1; cmd_fill = 8'h55; end
      else cmd_valid = 1'b0;
      #1;
      if (n == 1) begin
        checks++; if (txbl_addr !== 10'd0 || txbl_wdata !== 8'h20 || txbl_wen !== 1'b1 || busy !== 1'b1) begin
          errors++; $display("FAIL fill_first got a=%0d d=%0h wen=%b busy=%b exp 0/20/1/1", txbl_addr, txbl_wdata, txbl_wen, busy); end
      end
      if (n == 33) begin
        checks++; if (txbl_addr !== 10'd32) begin errors++; $display("FAIL fill_rowwrap got %0d exp 32", txbl_addr); end
      end
      if (n == 100) begin
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_busy got %b exp 0", cmd_ready); end
      end
      if (done) nd = n;
    end
    cmd_valid = 1'b0;
    checks++; if (nd !== 961) begin errors++; $display("FAIL fill_done_cycle got %0d exp 961", nd); end
    @(negedge clk); #1;
    checks++; if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL fill_after_done got done=%b rdy=%b busy=%b exp 0/1/0", done, cmd_ready, busy); end
    checks++; if (wr_count - w0 !== 960) begin errors++; $display("FAIL fill_writes got %0d exp 960", wr_count - w0); end
    checks++; if (count_bad_const(8'h20, 0, 960) !== 0) begin
      errors++; $display("FAIL fill_table got %0d bad exp 0", count_bad_const(8'h20, 0, 960)); end
    checks++; if (count_bad_const(8'hAA, 960, 1024) !== 0) begin
      errors++; $display("FAIL fill_rows_30_31 got %0d bad exp 0", count_bad_const(8'hAA, 960, 1024)); end
  endtask

  task automatic test_scroll;
    int n = 0, nd = 0, w0;
    init_table(1, 8'h00);
    w0 = wr_count;
    start_cmd(1'b1, 8'h00);
    while (n < 4000 && nd == 0) begin
      @(negedge clk);
      n++;
      #1;
      if (n == 1) begin
        checks++; if (txbl_addr !== 10'd32 || txbl_wen !== 1'b0 || eng_active !== 1'b1) begin
          errors++; $display("FAIL scroll_rd got a=%0d wen=%b act=%b exp 32/0/1", txbl_addr, txbl_wen, eng_active); end
      end
      if (n == 2) begin
        checks++; if (txbl_addr !== 10'd0 || txbl_wdata !== 8'd1 || txbl_wen !== 1'b1) begin
          errors++; $display("FAIL scroll_wr got a=%0d d=%0h wen=%b exp 0/1/1", txbl_addr, txbl_wdata, txbl_wen); end
      end
      if (done) nd = n;
    end
    checks++; if (nd !== 1889) begin errors++; $display("FAIL scroll_done_cycle got %0d exp 1889", nd); end
    checks++; if (wr_count - w0 !== 960) begin errors++; $display("FAIL scroll_writes got %0d exp 960", wr_count - w0); end
    checks++; if (count_bad_scroll(8'h00, -1) !== 0) begin
      errors++; $display("FAIL scroll_table got %0d bad exp 0", count_bad_scroll(8'h00, -1)); end
  endtask

  task automatic test_stall;
    int nd, st, ov0;
    init_table(1, 8'h00);
    ov0 = bad_overlap;
    start_cmd(1'b1, 8'h00);
    wait_done(6000, 3, nd, st);
    checks++; if (nd - st !== 1889 || st == 0) begin
      errors++; $display("FAIL stall_duration got %0d-%0d exp 1889", nd, st); end
    checks++; if (bad_overlap - ov0 !== 0) begin
      errors++; $display("FAIL stall_wen_overlap got %0d exp 0", bad_overlap - ov0); end
    checks++; if (count_bad_scroll(8'h00, -1) !== 0) begin
      errors++; $display("FAIL stall_table got %0d bad exp 0", count_bad_scroll(8'h00, -1)); end
  endtask

  task automatic test_cpu_stall;
    int n = 0, nd = 0;
    init_table(1, 8'h00);
    start_cmd(1'b1, 8'h00);
    while (n < 4000 && nd == 0) begin
      @(negedge clk);
      n++;
      cpu_req   = (n >= 3 && n < 103);
      cpu_we    = (n == 50);
      cpu_addr  = 10'd33;
      cpu_wdata = 8'h77;
      #1;
      if (n == 3) begin
        checks++; if (txbl_addr !== 10'd33 || eng_active !== 1'b0) begin
          errors++; $display("FAIL cpu_stall_enter got a=%0d act=%b exp 33/0", txbl_addr, eng_active); end
      end
      if (n == 60) begin
        checks++; if (eng_active !== 1'b0 || txbl_wen !== 1'b0 || busy !== 1'b1) begin
          errors++; $display("FAIL cpu_stall_hold got act=%b wen=%b busy=%b exp 0/0/1", eng_active, txbl_wen, busy); end
      end
      if (n == 103) begin
        checks++; if (txbl_addr !== 10'd33 || eng_active !== 1'b1 || txbl_wen !== 1'b0) begin
          errors++; $display("FAIL cpu_stall_resume got a=%0d act=%b wen=%b exp 33/1/0", txbl_addr, eng_active, txbl_wen); end
      end
      if (n == 104) begin
        checks++; if (txbl_addr !== 10'd1 || txbl_wdata !== 8'h77) begin
          errors++; $display("FAIL cpu_stall_copy got a=%0d d=%0h exp 1/77", txbl_addr, txbl_wdata); end
      end
      if (done) nd = n;
    end
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    checks++; if (nd !== 1989) begin errors++; $display("FAIL cpu_stall_done got %0d exp 1989", nd); end
    checks++; if (mem[1] !== 8'h77 || count_bad_scroll(8'h00, 1) !== 0) begin
      errors++; $display("FAIL cpu_stall_table got mem1=%0h bad=%0d exp 77/0", mem[1], count_bad_scroll(8'h00, 1)); end
  endtask

  task automatic test_back_to_back;
    int n = 0, nd = 0, st;
    init_table(0, 8'hAA);
    start_cmd(1'b0, 8'h11);
    while (n < 2000 && nd == 0) begin
      @(negedge clk);
      n++;
      #1;
      if (done) nd = n;
    end
    cmd_valid = 1'b1;
    cmd_op    = 1'b0;
    cmd_fill  = 8'h33;
    checks++; if (nd !== 961 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_done_ready got n=%0d rdy=%b exp 961/0", nd, cmd_ready); end
    @(negedge clk); #1;
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got rdy=%b busy=%b exp 1/0", cmd_ready, busy); end
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    checks++; if (busy !== 1'b1 || txbl_addr !== 10'd0 || txbl_wdata !== 8'h33) begin
      errors++; $display("FAIL b2b_accept got busy=%b a=%0d d=%0h exp 1/0/33", busy, txbl_addr, txbl_wdata); end
    wait_done(2000, 0, nd, st);
    checks++; if (nd !== 960) begin errors++; $display("FAIL b2b_second_done got %0d exp 960", nd); end
    checks++; if (count_bad_const(8'h33, 0, 960) !== 0) begin
      errors++; $display("FAIL b2b_table got %0d bad exp 0", count_bad_const(8'h33, 0, 960)); end
  endtask

  task automatic test_reset_mid;
    int n = 0, d0;
    init_table(0, 8'h00);
    d0 = done_count;
    start_cmd(1'b0, 8'h5A);
    while (n < 200) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || txbl_wen !== 1'b0) begin
      errors++; $display("FAIL rst_mid_outputs got busy=%b rdy=%b wen=%b exp 0/1/0", busy, cmd_ready, txbl_wen); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (done_count - d0 !== 0) begin errors++; $display("FAIL rst_mid_done got %0d exp 0", done_count - d0); end
    checks++; if (count_bad_const(8'h5A, 0, 199) !== 0 || count_bad_const(8'h00, 199, 1024) !== 0) begin
      errors++; $display("FAIL rst_mid_table got %0d/%0d bad exp 0/0",
                         count_bad_const(8'h5A, 0, 199), count_bad_const(8'h00, 199, 1024)); end
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = 1'b0; cmd_fill = 8'h00;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    init_go = 1'b0; init_mode = 0; init_val = 8'h00;
    test_reset;
    test_fill;
    test_scroll;
    test_stall;
    test_cpu_stall;
    test_back_to_back;
    test_reset_mid;
    checks++; if (bad_range !== 0 || bad_active !== 0) begin
      errors++; $display("FAIL write_discipline got range=%0d inactive=%0d exp 0/0", bad_range, bad_active); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
